sample_ticks_to_midi_note_number: RTL and testbench

//   Pitch detector that inverts the note-to-period mapping. Measures the period of a 1-bit

---
 rtl/sample_ticks_to_midi_note_number.sv | 157 +++++++++++++++
 tb/tb_sample_ticks_to_midi_note_number.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/sample_ticks_to_midi_note_number.sv
// Pitch detector: measures the period of a 1-bit waveform in sample ticks and
// returns the nearest MIDI note by binary-searching a note-to-period table.
module sample_ticks_to_midi_note_number #(
  parameter int TICK_W        = 24,
  parameter int TIMEOUT_TICKS = 4095
) (
  input  logic              mclk,
  input  logic              rst_n,
  input  logic              sample_tick,
  input  logic              wave_in,
  output logic              note_valid,
  output logic [6:0]        note_number,
  output logic [TICK_W-1:0] period_ticks,
  output logic              range_err,
  output logic              no_signal
);

  typedef enum logic [1:0] {IDLE = 2'd0, MEASURE = 2'd1, SEARCH = 2'd2, ROUND = 2'd3} state_t;

  localparam logic [TICK_W-1:0] TIMEOUT = TICK_W'(TIMEOUT_TICKS);
  localparam logic [TICK_W-1:0] ONE     = TICK_W'(1);
  localparam logic [TICK_W-1:0] ZERO    = {TICK_W{1'b0}};

  // floor(24414 / f(n)); truncation keeps e.g. note 68 at 58 and note 120 at 2
  function automatic logic [11:0] ticks_rom(input logic [6:0] idx);
    logic [11:0] t;
    case (idx)
      7'd0:  t = 12'd2986; 7'd1:  t = 12'd2818; 7'd2:  t = 12'd2660; 7'd3:  t = 12'd2511;
      7'd4:  t = 12'd2370; 7'd5:  t = 12'd2237; 7'd6:  t = 12'd2111; 7'd7:  t = 12'd1993;
      7'd8:  t = 12'd1881; 7'd9:  t = 12'd1775; 7'd10: t = 12'd1675; 7'd11: t = 12'd1581;
      7'd12: t = 12'd1493; 7'd13: t = 12'd1409; 7'd14: t = 12'd1330; 7'd15: t = 12'd1255;
      7'd16: t = 12'd1185; 7'd17: t = 12'd1118; 7'd18: t = 12'd1055; 7'd19: t = 12'd996;
      7'd20: t = 12'd940;  7'd21: t = 12'd887;  7'd22: t = 12'd837;  7'd23: t = 12'd790;
      7'd24: t = 12'd746;  7'd25: t = 12'd704;  7'd26: t = 12'd665;  7'd27: t = 12'd627;
      7'd28: t = 12'd592;  7'd29: t = 12'd559;  7'd30: t = 12'd527;  7'd31: t = 12'd498;
      7'd32: t = 12'd470;  7'd33: t = 12'd443;  7'd34: t = 12'd418;  7'd35: t = 12'd395;
      7'd36: t = 12'd373;  7'd37: t = 12'd352;  7'd38: t = 12'd332;  7'd39: t = 12'd313;
      7'd40: t = 12'd296;  7'd41: t = 12'd279;  7'd42: t = 12'd263;  7'd43: t = 12'd249;
      7'd44: t = 12'd235;  7'd45: t = 12'd221;  7'd46: t = 12'd209;  7'd47: t = 12'd197;
      7'd48: t = 12'd186;  7'd49: t = 12'd176;  7'd50: t = 12'd166;  7'd51: t = 12'd156;
      7'd52: t = 12'd148;  7'd53: t = 12'd139;  7'd54: t = 12'd131;  7'd55: t = 12'd124;
      7'd56: t = 12'd117;  7'd57: t = 12'd110;  7'd58: t = 12'd104;  7'd59: t = 12'd98;
      7'd60: t = 12'd93;   7'd61: t = 12'd88;   7'd62: t = 12'd83;   7'd63: t = 12'd78;
      7'd64: t = 12'd74;   7'd65: t = 12'd69;   7'd66: t = 12'd65;   7'd67: t = 12'd62;
      7'd68: t = 12'd58;   7'd69: t = 12'd55;   7'd70: t = 12'd52;   7'd71: t = 12'd49;
      7'd72: t = 12'd46;   7'd73: t = 12'd44;   7'd74: t = 12'd41;   7'd75: t = 12'd39;
      7'd76: t = 12'd37;   7'd77: t = 12'd34;   7'd78: t = 12'd32;   7'd79: t = 12'd31;
      7'd80: t = 12'd29;   7'd81: t = 12'd27;   7'd82: t = 12'd26;   7'd83: t = 12'd24;
      7'd84: t = 12'd23;   7'd85: t = 12'd22;   7'd86: t = 12'd20;   7'd87: t = 12'd19;
      7'd88: t = 12'd18;   7'd89: t = 12'd17;   7'd90: t = 12'd16;   7'd91: t = 12'd15;
      7'd92: t = 12'd14;   7'd93, 7'd94: t = 12'd13; 7'd95: t = 12'd12;
      7'd96, 7'd97: t = 12'd11; 7'd98: t = 12'd10; 7'd99, 7'd100: t = 12'd9;
      7'd101, 7'd102: t = 12'd8; 7'd103, 7'd104: t = 12'd7;
      7'd105, 7'd106, 7'd107: t = 12'd6; 7'd108, 7'd109, 7'd110: t = 12'd5;
      7'd111, 7'd112, 7'd113, 7'd114: t = 12'd4;
      7'd115, 7'd116, 7'd117, 7'd118, 7'd119: t = 12'd3;
      7'd120, 7'd121, 7'd122, 7'd123, 7'd124, 7'd125, 7'd126: t = 12'd2;
      default: t = 12'd1;
    endcase
    return t;
  endfunction

  state_t            state_q;
  logic              wave_prev_q;
  logic [TICK_W-1:0] cnt_q, p_q, period_q;
  logic [6:0]        idx_q, note_q;
  logic [2:0]        step_q;
  logic              note_valid_q, range_err_q, no_signal_q;

  logic              edge_s, probe_gt_s, range_s;
  logic [TICK_W-1:0] cnt_d, t_hi_s, t_lo_s;
  logic [6:0]        cand_s, note_d;

  // Search probes position cand-1: if it is still above P, the answer lies at or beyond cand.
  always_comb begin
    edge_s     = sample_tick & wave_in & ~wave_prev_q;
    cnt_d      = (cnt_q >= TIMEOUT) ? TIMEOUT : cnt_q + ONE;
    cand_s     = idx_q | (7'd1 << (3'd6 - step_q));
    probe_gt_s = TICK_W'(ticks_rom(cand_s - 7'd1)) > p_q;
    t_hi_s     = TICK_W'(ticks_rom(idx_q));
    t_lo_s     = TICK_W'(ticks_rom(idx_q - 7'd1));
    range_s    = p_q > TICK_W'(ticks_rom(7'd0));
    if (range_s) begin
      note_d = 7'd0;
    end else if ((idx_q != 7'd0) && ((t_lo_s - p_q) < (p_q - t_hi_s))) begin
      note_d = idx_q - 7'd1;
    end else begin
      note_d = idx_q;
    end
  end

  // Measurement/search FSM with registered outputs
  always_ff @(posedge mclk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      wave_prev_q  <= 1'b0;
      cnt_q        <= ZERO;
      p_q          <= ZERO;
      idx_q        <= 7'd0;
      step_q       <= 3'd0;
      note_valid_q <= 1'b0;
      note_q       <= 7'd0;
      period_q     <= ZERO;
      range_err_q  <= 1'b0;
      no_signal_q  <= 1'b1;
    end else begin
      note_valid_q <= 1'b0;
      if (sample_tick) wave_prev_q <= wave_in;
      case (state_q)
        IDLE: begin
          if (edge_s) begin
            cnt_q   <= ZERO;
            state_q <= MEASURE;
          end
        end
        MEASURE: begin
          if (edge_s) begin
            p_q     <= cnt_q + ONE;
            cnt_q   <= ZERO;
            idx_q   <= 7'd0;
            step_q  <= 3'd0;
            state_q <= SEARCH;
          end else if (sample_tick) begin
            cnt_q <= cnt_d;
            if (cnt_d == TIMEOUT) begin
              no_signal_q <= 1'b1;
              state_q     <= IDLE;
            end
          end
        end
        SEARCH: begin
          if (sample_tick) cnt_q <= edge_s ? ZERO : cnt_d;
          if (probe_gt_s) idx_q <= cand_s;
          step_q <= step_q + 3'd1;
          if (step_q == 3'd6) state_q <= ROUND;
        end
        ROUND: begin
          if (sample_tick) cnt_q <= edge_s ? ZERO : cnt_d;
          note_valid_q <= 1'b1;
          note_q       <= note_d;
          period_q     <= p_q;
          range_err_q  <= range_s;
          no_signal_q  <= 1'b0;
          state_q      <= MEASURE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign note_valid   = note_valid_q;
  assign note_number  = note_q;
  assign period_ticks = period_q;
  assign range_err    = range_err_q;
  assign no_signal    = no_signal_q;

endmodule

// File: tb/tb_sample_ticks_to_midi_note_number.sv
// Directed bench for the period-to-MIDI-note detector; quiet (non-edge) sample ticks
// run back-to-back to keep long periods short, edge ticks are followed by 16 clocks.
module tb_sample_ticks_to_midi_note_number;

  logic        mclk = 1'b0;
  logic        rst_n, sample_tick, wave_in;
  logic        note_valid, range_err, no_signal;
  logic [6:0]  note_number;
  logic [23:0] period_ticks;

  int checks = 0, failures = 0;
  int nv_cnt, nv_note, nv_period, nv_err, nv_lat, since_edge;
  int ref_tbl[128];

  sample_ticks_to_midi_note_number #(.TICK_W(24), .TIMEOUT_TICKS(4095)) dut (
    .mclk(mclk), .rst_n(rst_n), .sample_tick(sample_tick), .wave_in(wave_in),
    .note_valid(note_valid), .note_number(note_number), .period_ticks(period_ticks),
    .range_err(range_err), .no_signal(no_signal)
  );

  always #5 mclk = ~mclk;

  function automatic int ref_ticks(input int n);
    real v;
    v = 24414.0 / (440.0 * $pow(2.0, (n - 69) / 12.0));
    return (v < 1.0) ? 1 : int'($floor(v));
  endfunction

  task automatic watch();
    since_edge++;
    if (note_valid === 1'b1) begin
      nv_cnt++;
      nv_note = note_number; nv_period = period_ticks; nv_err = range_err; nv_lat = since_edge;
    end
  endtask

  task automatic tick(input logic w, input int gap);
    wave_in = w; sample_tick = 1'b1;
    @(negedge mclk); watch(); sample_tick = 1'b0;
    for (int i = 1; i < gap; i++) begin @(negedge mclk); watch(); end
  endtask

  // Rising edge, then p-1 further ticks (high for the first half, low before the next edge)
  task automatic edge_then(input int p);
    nv_cnt = 0; since_edge = 0;
    tick(1'b1, 16);
    for (int i = 1; i < p; i++) tick((i < p / 2) ? 1'b1 : 1'b0, 1);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; sample_tick = 1'b0; wave_in = 1'b0; nv_cnt = 0; since_edge = 0;
    repeat (3) @(negedge mclk);
    rst_n = 1'b1;
    @(negedge mclk);
    checks++; if (note_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0d exp=0", note_valid); end
    checks++; if (note_number !== 7'd0) begin failures++; $display("FAIL reset_note got=%0d exp=0", note_number); end
    checks++; if (period_ticks !== 24'd0) begin failures++; $display("FAIL reset_period got=%0d exp=0", period_ticks); end
    checks++; if (range_err !== 1'b0) begin failures++; $display("FAIL reset_range got=%0d exp=0", range_err); end
    checks++; if (no_signal !== 1'b1) begin failures++; $display("FAIL reset_nosig got=%0d exp=1", no_signal); end
  endtask

  task automatic test_first_lock();
    edge_then(55);
    checks++; if (nv_cnt !== 0) begin failures++; $display("FAIL arm_no_note got=%0d exp=0", nv_cnt); end
    checks++; if (no_signal !== 1'b1) begin failures++; $display("FAIL arm_nosig got=%0d exp=1", no_signal); end
    edge_then(93);
    checks++; if (nv_cnt !== 1) begin failures++; $display("FAIL lock_pulses got=%0d exp=1", nv_cnt); end
    checks++; if (nv_note !== 69) begin failures++; $display("FAIL lock_note got=%0d exp=69", nv_note); end
    checks++; if (nv_period !== 55) begin failures++; $display("FAIL lock_period got=%0d exp=55", nv_period); end
    checks++; if (nv_err !== 0) begin failures++; $display("FAIL lock_range got=%0d exp=0", nv_err); end
    checks++; if (nv_lat !== 9) begin failures++; $display("FAIL lock_latency got=%0d exp=9", nv_lat); end
    checks++; if (no_signal !== 1'b0) begin failures++; $display("FAIL lock_nosig got=%0d exp=0", no_signal); end
  endtask

  // Each call's edge reports the previous period: 93->60, 54->69, 60->68 (tie), 2->120, 3000->0/err, 55->69
  task automatic test_periods();
    int nxt[6]   = '{54, 60, 2, 3000, 55, 55};
    int e_note[6] = '{60, 69, 68, 120, 0, 69};
    int e_per[6]  = '{93, 54, 60, 2, 3000, 55};
    int e_err[6]  = '{0, 0, 0, 0, 1, 0};
    for (int k = 0; k < 6; k++) begin
      edge_then(nxt[k]);
      checks++;
      if (nv_cnt !== 1 || nv_note !== e_note[k] || nv_period !== e_per[k] || nv_err !== e_err[k]) begin
        failures++;
        $display("FAIL period_%0d got pulses=%0d note=%0d period=%0d err=%0d exp note=%0d period=%0d err=%0d",
                 e_per[k], nv_cnt, nv_note, nv_period, nv_err, e_note[k], e_per[k], e_err[k]);
      end
    end
  endtask

  task automatic test_timeout();
    nv_cnt = 0;
    for (int i = 0; i < 4040; i++) tick(1'b0, 1);
    checks++; if (no_signal !== 1'b0) begin failures++; $display("FAIL timeout_early got=%0d exp=0", no_signal); end
    tick(1'b0, 1);
    checks++; if (no_signal !== 1'b1) begin failures++; $display("FAIL timeout_rise got=%0d exp=1", no_signal); end
    checks++; if (note_number !== 7'd69) begin failures++; $display("FAIL timeout_note_hold got=%0d exp=69", note_number); end
    checks++; if (nv_cnt !== 0) begin failures++; $display("FAIL timeout_pulses got=%0d exp=0", nv_cnt); end
    edge_then(55);
    checks++; if (nv_cnt !== 0 || no_signal !== 1'b1) begin failures++;
      $display("FAIL rearm got pulses=%0d nosig=%0d exp 0/1", nv_cnt, no_signal); end
    edge_then(55);
    checks++; if (nv_cnt !== 1 || nv_note !== 69 || no_signal !== 1'b0) begin failures++;
      $display("FAIL relock got pulses=%0d note=%0d nosig=%0d exp 1/69/0", nv_cnt, nv_note, no_signal); end
  endtask

  task automatic test_reset_in_search();
    nv_cnt = 0; since_edge = 0;
    wave_in = 1'b1; sample_tick = 1'b1;
    @(negedge mclk); watch(); sample_tick = 1'b0;
    repeat (3) begin @(negedge mclk); watch(); end
    rst_n = 1'b0;
    @(negedge mclk); watch(); rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin @(negedge mclk); watch(); end
    checks++; if (nv_cnt !== 0) begin failures++; $display("FAIL abort_pulses got=%0d exp=0", nv_cnt); end
    checks++; if (note_number !== 7'd0 || period_ticks !== 24'd0 || range_err !== 1'b0 || no_signal !== 1'b1) begin
      failures++;
      $display("FAIL abort_outputs got note=%0d period=%0d err=%0d nosig=%0d exp 0/0/0/1",
               note_number, period_ticks, range_err, no_signal);
    end
    edge_then(55);
    checks++; if (nv_cnt !== 0) begin failures++; $display("FAIL abort_rearm got=%0d exp=0", nv_cnt); end
    edge_then(55);
    checks++; if (nv_cnt !== 1 || nv_note !== 69 || nv_period !== 55) begin failures++;
      $display("FAIL abort_relock got pulses=%0d note=%0d period=%0d exp 1/69/55", nv_cnt, nv_note, nv_period); end
  endtask

  // Period of exactly table[n] must return the lowest index holding that value (n=127 needs P=1, not producible)
  task automatic test_sweep();
    int exp_n;
    edge_then(ref_tbl[0]);
    for (int n = 1; n < 128; n++) begin
      edge_then((n < 127) ? ref_tbl[n] : 2);
      exp_n = n - 1;
      for (int j = n - 1; j >= 0; j--) if (ref_tbl[j] == ref_tbl[n - 1]) exp_n = j;
      checks++;
      if (nv_cnt !== 1 || nv_note !== exp_n || nv_period !== ref_tbl[n - 1] || nv_err !== 0) begin
        failures++;
        $display("FAIL sweep_%0d got pulses=%0d note=%0d period=%0d err=%0d exp note=%0d period=%0d",
                 n - 1, nv_cnt, nv_note, nv_period, nv_err, exp_n, ref_tbl[n - 1]);
      end
    end
  endtask

  initial begin
    for (int n = 0; n < 128; n++) ref_tbl[n] = ref_ticks(n);
    test_reset();
    test_first_lock();
    test_periods();
    test_timeout();
    test_reset_in_search();
    test_sweep();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
